// File: rtl/match_pkg.sv
// Shared types and default widths for the match window counter.
// State encoding is shared by the top FSM; widths are the default build sizes.
package match_pkg;
   localparam int CNT_W_DEF = 8;
   localparam int WIN_W_DEF = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;
endpackage

// File: rtl/match_window_counter_window_timer.sv
// Bit-time counter for back-to-back windows: latches the window length, pulses o_win_end
// on the last bit-time of each window, restarts with no gap. Latency 0 (o_win_end is combinational).
module window_timer #(
   parameter int WIN_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIN_W-1:0] i_win_len,
   output logic             o_win_end
);
   localparam logic [WIN_W-1:0] ONE = {{(WIN_W-1){1'b0}}, 1'b1};

   logic [WIN_W-1:0] r_len;
   logic [WIN_W-1:0] r_cnt;
   logic             r_run;
   logic [WIN_W-1:0] w_len_eff;

   // A zero length would never reach len-1, so it behaves as a 1-bit window.
   assign w_len_eff = (i_win_len == '0) ? ONE : i_win_len;
   assign o_win_end = r_run && (r_cnt == (r_len - ONE));

   always_ff @(posedge i_clk) begin
      if (i_rst || i_abort) begin
         r_run <= 1'b0;
         r_cnt <= '0;
         r_len <= ONE;
      end else if (i_start) begin
         r_run <= 1'b1;
         r_cnt <= '0;
         r_len <= w_len_eff;
      end else if (r_run) begin
         if (o_win_end) begin
            r_cnt <= '0;
            r_len <= w_len_eff;
         end else begin
            r_cnt <= r_cnt + ONE;
         end
      end
   end
endmodule

// File: rtl/match_window_counter.sv
// Counts detector match pulses over back-to-back windows and publishes each count through a
// valid/ready result register with threshold alarm and sticky lost flag. MATCH_CNT_SAT_EN selects saturation.
module match_window_counter
   import match_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_match_in,
   input  logic [WIN_W-1:0] i_win_len,
   input  logic [CNT_W-1:0] i_thr,
   output logic [CNT_W-1:0] o_count_out,
   output logic             o_alarm,
   output logic             o_count_valid,
   input  logic             i_count_ready,
   output logic             o_lost,
   output logic             o_sat
);
   state_t           r_state;
   logic [CNT_W-1:0] r_acc;
   logic [CNT_W-1:0] r_count;
   logic             r_alarm;
   logic             r_valid;
   logic             r_lost;
   logic [CNT_W-1:0] w_cand;
   logic [CNT_W-1:0] w_match_ext;
   logic             w_start;
   logic             w_abort;
   logic             w_win_end;
   logic             w_load;

   assign w_match_ext = {{(CNT_W-1){1'b0}}, i_match_in};
   assign w_start     = (r_state == IDLE) && i_en;
   assign w_abort     = (r_state == COUNT) && !i_en;
   assign w_load      = (r_state == COUNT) && i_en && w_win_end && (!r_valid || i_count_ready);

   window_timer #(.WIN_W(WIN_W)) u_timer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_start   (w_start),
      .i_abort   (w_abort),
      .i_win_len (i_win_len),
      .o_win_end (w_win_end)
   );

`ifdef MATCH_CNT_SAT_EN
   logic [CNT_W:0] w_sum;
   logic           w_cand_clip;
   logic           r_clip;
   logic           r_sat;

   assign w_sum       = {1'b0, r_acc} + {1'b0, w_match_ext};
   assign w_cand      = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
   assign w_cand_clip = r_clip | w_sum[CNT_W];
   assign o_sat       = r_sat;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_clip <= 1'b0;
         r_sat  <= 1'b0;
      end else begin
         if (w_start || w_abort) begin
            r_clip <= 1'b0;
         end else if (r_state == COUNT) begin
            r_clip <= w_win_end ? 1'b0 : w_cand_clip;
         end
         if (w_load) begin
            r_sat <= w_cand_clip;
         end
      end
   end
`else
   assign w_cand = r_acc + w_match_ext;
   assign o_sat  = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_count <= '0;
         r_alarm <= 1'b0;
         r_valid <= 1'b0;
         r_lost  <= 1'b0;
      end else begin
         if (r_valid && i_count_ready) begin
            r_valid <= 1'b0;
         end
         if (r_state == IDLE) begin
            // The match seen on the enabling cycle belongs to the first window.
            if (i_en) begin
               r_state <= COUNT;
               r_acc   <= w_match_ext;
            end
         end else if (!i_en) begin
            r_state <= IDLE;
            r_acc   <= '0;
         end else if (w_win_end) begin
            r_acc <= '0;
            if (w_load) begin
               r_count <= w_cand;
               r_alarm <= (w_cand >= i_thr);
               r_valid <= 1'b1;
            end else begin
               r_lost <= 1'b1;
            end
         end else begin
            r_acc <= w_cand;
         end
      end
   end

   assign o_count_out   = r_count;
   assign o_alarm       = r_alarm;
   assign o_count_valid = r_valid;
   assign o_lost        = r_lost;
endmodule

// File: tb/tb_match_window_counter.sv
// Self-checking bench for match_window_counter: directed scenarios plus randomized windows
// checked against a window-arithmetic reference model. Honours MATCH_CNT_SAT_EN.
module tb_match_window_counter;
`ifdef MATCH_CNT_SAT_EN
   localparam bit SAT_MODE = 1'b1;
`else
   localparam bit SAT_MODE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       match_in;
   logic [7:0] win_len;
   logic [7:0] thr;
   logic [1:0] thr2;
   logic       ready;
   logic [7:0] count_out;
   logic       alarm, count_valid, lost, sat;
   logic [1:0] count_out2;
   logic       alarm2, count_valid2, lost2, sat2;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   match_window_counter #(.CNT_W(8), .WIN_W(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_match_in(match_in), .i_win_len(win_len),
      .i_thr(thr), .o_count_out(count_out), .o_alarm(alarm), .o_count_valid(count_valid),
      .i_count_ready(ready), .o_lost(lost), .o_sat(sat)
   );

   match_window_counter #(.CNT_W(2), .WIN_W(8)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_match_in(match_in), .i_win_len(win_len),
      .i_thr(thr2), .o_count_out(count_out2), .o_alarm(alarm2), .o_count_valid(count_valid2),
      .i_count_ready(ready), .o_lost(lost2), .o_sat(sat2)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drives one bit-time per cycle, bit i of pat on cycle i.
   task automatic run_bits(input logic [15:0] pat, input int n);
      logic [15:0] p;
      p = pat;
      for (int i = 0; i < n; i++) begin
         match_in = p[i];
         tick();
      end
      match_in = 1'b0;
   endtask

   task automatic reset_dut();
      rst = 1'b1; en = 1'b0; match_in = 1'b0; ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; match_in = 1'b0; ready = 1'b0;
      win_len = 8'd4; thr = 8'd0; thr2 = 2'd3;
      tick(); tick();
      rst = 1'b0;
      n_total++; if ({count_out, alarm, count_valid, lost, sat} !== 12'd0)
         $display("FAIL reset_outputs got %h want 0", {count_out, alarm, count_valid, lost, sat}); else n_pass++;
      n_total++; if ({count_out2, alarm2, count_valid2, lost2, sat2} !== 6'd0)
         $display("FAIL reset_outputs2 got %h want 0", {count_out2, alarm2, count_valid2, lost2, sat2}); else n_pass++;
   endtask

   task automatic test_basic();
      reset_dut();
      win_len = 8'd8; thr = 8'd2; ready = 1'b1; en = 1'b1;
      tick();
      run_bits(16'b0000_0000_0010_0100, 7);
      n_total++; if (count_valid !== 1'b0) $display("FAIL t1_mid_valid got %b want 0", count_valid); else n_pass++;
      run_bits(16'h0000, 1);
      n_total++; if (count_out !== 8'd2) $display("FAIL t1_count got %0d want 2", count_out); else n_pass++;
      n_total++; if (alarm !== 1'b1) $display("FAIL t1_alarm got %b want 1", alarm); else n_pass++;
      n_total++; if (count_valid !== 1'b1) $display("FAIL t1_valid got %b want 1", count_valid); else n_pass++;
      n_total++; if (lost !== 1'b0) $display("FAIL t1_lost got %b want 0", lost); else n_pass++;
      tick();
      n_total++; if (count_valid !== 1'b0) $display("FAIL t1_valid_drop got %b want 0", count_valid); else n_pass++;
      n_total++; if (count_out !== 8'd2) $display("FAIL t1_count_hold got %0d want 2", count_out); else n_pass++;
      en = 1'b0; tick();
   endtask

   task automatic test_lost();
      reset_dut();
      win_len = 8'd4; thr = 8'd3; ready = 1'b0; en = 1'b1;
      tick();
      run_bits(16'b1111, 4);
      n_total++; if (count_out !== 8'd4) $display("FAIL t2_w0_count got %0d want 4", count_out); else n_pass++;
      n_total++; if (lost !== 1'b0) $display("FAIL t2_w0_lost got %b want 0", lost); else n_pass++;
      run_bits(16'b0001, 4);
      n_total++; if (count_out !== 8'd4) $display("FAIL t2_w1_count got %0d want 4", count_out); else n_pass++;
      n_total++; if (lost !== 1'b1) $display("FAIL t2_w1_lost got %b want 1", lost); else n_pass++;
      n_total++; if (count_valid !== 1'b1) $display("FAIL t2_w1_valid got %b want 1", count_valid); else n_pass++;
      n_total++; if (alarm !== 1'b1) $display("FAIL t2_alarm got %b want 1", alarm); else n_pass++;
      ready = 1'b1; en = 1'b0;
      tick();
      n_total++; if (count_valid !== 1'b0) $display("FAIL t2_valid_drop got %b want 0", count_valid); else n_pass++;
      n_total++; if (lost !== 1'b1) $display("FAIL t2_lost_sticky got %b want 1", lost); else n_pass++;
   endtask

   task automatic test_ready_on_end();
      reset_dut();
      win_len = 8'd4; thr = 8'd10; ready = 1'b0; en = 1'b1;
      tick();
      run_bits(16'b0111, 4);
      run_bits(16'b0001, 3);
      n_total++; if (count_out !== 8'd3) $display("FAIL t3_w0_count got %0d want 3", count_out); else n_pass++;
      ready = 1'b1;
      run_bits(16'b0000, 1);
      ready = 1'b0;
      n_total++; if (count_valid !== 1'b1) $display("FAIL t3_valid_stays got %b want 1", count_valid); else n_pass++;
      n_total++; if (count_out !== 8'd1) $display("FAIL t3_w1_count got %0d want 1", count_out); else n_pass++;
      n_total++; if (lost !== 1'b0) $display("FAIL t3_lost got %b want 0", lost); else n_pass++;
      n_total++; if (alarm !== 1'b0) $display("FAIL t3_alarm got %b want 0", alarm); else n_pass++;
      en = 1'b0; tick();
   endtask

   task automatic test_boundary();
      reset_dut();
      win_len = 8'd4; thr = 8'd1; ready = 1'b1; en = 1'b1;
      tick();
      run_bits(16'b1000, 4);
      n_total++; if (count_out !== 8'd1) $display("FAIL t4_w0_count got %0d want 1", count_out); else n_pass++;
      run_bits(16'b0001, 1);
      n_total++; if (count_valid !== 1'b0) $display("FAIL t4_consumed got %b want 0", count_valid); else n_pass++;
      run_bits(16'b0000, 3);
      n_total++; if (count_out !== 8'd1) $display("FAIL t4_w1_count got %0d want 1", count_out); else n_pass++;
      n_total++; if (count_valid !== 1'b1) $display("FAIL t4_w1_valid got %b want 1", count_valid); else n_pass++;
      en = 1'b0; tick();
   endtask

   task automatic test_sat();
      logic [1:0] exp2;
      logic       exp_sat2;
      reset_dut();
      win_len = 8'd8; thr = 8'd0; thr2 = 2'd3; ready = 1'b1; en = 1'b1;
      tick();
      run_bits(16'b0001_1111, 8);
      exp2     = SAT_MODE ? 2'd3 : 2'(5 % 4);
      exp_sat2 = SAT_MODE;
      n_total++; if (count_out2 !== exp2) $display("FAIL t5_count2 got %0d want %0d", count_out2, exp2); else n_pass++;
      n_total++; if (sat2 !== exp_sat2) $display("FAIL t5_sat2 got %b want %b", sat2, exp_sat2); else n_pass++;
      n_total++; if (count_out !== 8'd5) $display("FAIL t5_count_wide got %0d want 5", count_out); else n_pass++;
      n_total++; if (sat !== 1'b0) $display("FAIL t5_sat_wide got %b want 0", sat); else n_pass++;
      en = 1'b0; tick();
   endtask

   task automatic test_abort();
      reset_dut();
      win_len = 8'd2; thr = 8'd0; ready = 1'b0; en = 1'b1; match_in = 1'b1;
      tick();
      run_bits(16'b11, 2);
      win_len = 8'd8;
      run_bits(16'b11, 2);
      n_total++; if ({count_valid, lost, count_out} !== {2'b11, 8'd3}) $display("FAIL t6_prestate got %h want 303", {count_valid, lost, count_out}); else n_pass++;
      run_bits(16'b110, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_total++; if ({count_out, alarm, count_valid, lost, sat} !== 12'd0)
         $display("FAIL t6_rst_outputs got %h want 0", {count_out, alarm, count_valid, lost, sat}); else n_pass++;
      win_len = 8'd4; ready = 1'b1;
      tick();
      run_bits(16'b0001, 4);
      n_total++; if (count_out !== 8'd1) $display("FAIL t6_rst_fresh got %0d want 1", count_out); else n_pass++;
      en = 1'b0; tick();
      win_len = 8'd8; en = 1'b1;
      tick();
      run_bits(16'b011, 3);
      en = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      n_total++; if (count_valid !== 1'b0) $display("FAIL t6_en_no_result got %b want 0", count_valid); else n_pass++;
      n_total++; if (count_out !== 8'd1) $display("FAIL t6_en_count_hold got %0d want 1", count_out); else n_pass++;
      win_len = 8'd4; en = 1'b1;
      tick();
      run_bits(16'b0110, 4);
      n_total++; if (count_out !== 8'd2) $display("FAIL t6_en_fresh got %0d want 2", count_out); else n_pass++;
      en = 1'b0; tick();
   endtask

   // Windows tile the cycles after the enabling one: with effective length L the first window
   // covers cycles 0..L (the enabling cycle's match included), later ones end every L cycles.
   task automatic test_random();
      int L, k, sum, m_cnt;
      bit m_valid, m_alarm, m_lost, is_end;
      for (int run = 0; run < 3; run++) begin
         reset_dut();
         win_len = 8'($urandom_range(0, 6));
         L = (win_len == 0) ? 1 : int'(win_len);
         sum = 0; m_cnt = 0; m_valid = 0; m_alarm = 0; m_lost = 0;
         en = 1'b1;
         for (k = 0; k < 60; k++) begin
            match_in = 1'($urandom_range(0, 1));
            ready    = 1'($urandom_range(0, 1));
            thr      = 8'($urandom_range(0, 3));
            is_end   = (k > 0) && (k % L == 0);
            sum      = sum + int'(match_in);
            if (is_end) begin
               if (!m_valid || ready) begin
                  m_cnt = sum; m_alarm = (sum >= int'(thr)); m_valid = 1;
               end else begin
                  m_lost = 1;
               end
               sum = 0;
            end else if (m_valid && ready) begin
               m_valid = 0;
            end
            tick();
            n_total++; if (count_valid !== m_valid) $display("FAIL rnd_valid run %0d cyc %0d got %b want %b", run, k, count_valid, m_valid); else n_pass++;
            n_total++; if (count_out !== 8'(m_cnt)) $display("FAIL rnd_count run %0d cyc %0d got %0d want %0d", run, k, count_out, m_cnt); else n_pass++;
            n_total++; if (alarm !== m_alarm) $display("FAIL rnd_alarm run %0d cyc %0d got %b want %b", run, k, alarm, m_alarm); else n_pass++;
            n_total++; if (lost !== m_lost) $display("FAIL rnd_lost run %0d cyc %0d got %b want %b", run, k, lost, m_lost); else n_pass++;
         end
         en = 1'b0; match_in = 1'b0;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_lost();
      test_ready_on_end();
      test_boundary();
      test_sat();
      test_abort();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
